calc_alu_sequencer: RTL and testbench
=====================================

Name: calc_alu_sequencer

Overview:
Initiator side of the calculator ALU interface. It takes keypad key events and accumulates decimal operands A and B and an operator. It then issues a single request to the ALU (en, operation, A, B), waits for valid with a timeout, and captures the result for display. It sits between the keypad decoder and the ALU and owns all ALU handshaking.

Parameters:
IN_SIZE, 4, operand width in bits; matches the ALU inSize; result width is 2*IN_SIZE.
TIMEOUT, 16, maximum cycles to wait for alu_valid before flagging an error.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
key_valid  in  1  one-cycle strobe; key_code is valid this cycle
key_code  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear
alu_en  out  1  request strobe to the ALU
alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
alu_a  out  IN_SIZE  operand A; held stable from issue until the request completes
alu_b  out  IN_SIZE  operand B; held stable from issue until the request completes
alu_result  in  2*IN_SIZE  ALU result
alu_valid  in  1  ALU result valid
disp_value  out  2*IN_SIZE  value to display
disp_valid  out  1  high while a completed result is shown
busy  out  1  high while a request is outstanding
error  out  1  high in the error state

Behaviour:
- Reset (asynchronous): state ENTER_A, A=B=0, op=00, timeout counter=0. All outputs are 0.
- Keys are sampled on the rising edge when key_valid=1. In ISSUE and WAIT, every key except clear is ignored.
- Clear (15) is accepted in any state. Next state is ENTER_A with A=B=0 and the counter cleared.
- ENTER_A:
  - Digit d: A <= A*10+d. If the result exceeds 2^IN_SIZE-1, go to ERR.
  - Op key: latch op, B <= 0, go to ENTER_B.
  - Equals: ignored.
- ENTER_B:
  - Digit: accumulates into B with the same overflow-to-ERR rule.
  - Op key: replaces the latched op.
  - Equals with op=div and B==0: go to ERR; no request is issued.
  - Equals otherwise: go to ISSUE.
- ISSUE (exactly 1 cycle): alu_en=1, busy=1.
  - alu_valid=1 in this cycle: capture the result, go to DONE. This supports zero-latency ALUs.
  - Otherwise: go to WAIT.
- WAIT: alu_en=0, busy=1, counter increments each cycle.
  - alu_valid=1: capture alu_result, go to DONE.
  - Counter reaches TIMEOUT-1 without valid: go to ERR.
  - Valid and timeout in the same cycle: valid wins.
- DONE: disp_value=result, disp_valid=1.
  - Digit: start a new A=d, go to ENTER_A.
  - Op key: chain. If result[2*IN_SIZE-1:IN_SIZE]==0, then A <= result[IN_SIZE-1:0], latch op, B <= 0, go to ENTER_B. Otherwise go to ERR.
  - Equals: ignored.
- ERR: error=1, disp_value=0. Only clear exits.
- alu_valid outside ISSUE/WAIT is ignored; a late response after a timeout or clear has no effect.
- disp_value by state:
  - A in ENTER_A.
  - B in ENTER_B.
  - Held result in ISSUE/WAIT/DONE; the previous result, or 0 after reset.
  - 0 in ERR.
  - Operand displays are zero-extended.
- Result bits are passed through raw; sub wrap-around is the ALU's concern.
- alu_a, alu_b and alu_op are registered and change only on key acceptance, never in ISSUE/WAIT.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants (KEY_ADD..KEY_CLR)
  - ALU op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - the state enum: ENTER_A, ENTER_B, ISSUE, WAIT, DONE, ERR
- Sub-module calc_operand_accum: decimal accumulator. It takes the current value and a digit, and returns next = value*10+digit plus an overflow flag. It is instantiated twice, once for A and once for B.

Test Plan:
- Keys 7,10,5,14; ALU asserts valid 3 cycles after en with result 12 -> alu_en high exactly 1 cycle with alu_a=7, alu_b=5, alu_op=00; busy for 4 cycles; then disp_value=12, disp_valid=1.
- Keys 1,6 (IN_SIZE=4) -> 16>15 so error=1 and alu_en is never asserted; then key 15 -> error=0, state ENTER_A, disp_value=0.
- Keys 9,13,0,14 -> error=1, no alu_en pulse; keys 7 and 14 in ERR are ignored.
- Keys 3,12,4,14 with the ALU never responding -> error=1 after TIMEOUT cycles of WAIT; an alu_valid pulse 5 cycles later leaves disp_valid=0.
- Chaining:
  - After result 12, keys 12,2,14 -> alu_a=12, alu_b=2, alu_op=10, result 24.
  - After result 20 (4*5), key 10 -> error=1.
  - Operator replacement: keys 8,10,11,3,14 -> alu_op=01, result 5.
- Assert rst while in WAIT, then deassert -> all outputs 0 immediately (asynchronously); a subsequent alu_valid is ignored and no capture occurs.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, ALU op encodings and sequencer states
package calc_pkg;

   // Keypad codes above the digits
   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_DIV = 4'd13;
   localparam logic [3:0] KEY_EQ  = 4'd14;
   localparam logic [3:0] KEY_CLR = 4'd15;

   // ALU operation encodings
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      ENTER_A,
      ENTER_B,
      ISSUE,
      WAIT,
      DONE,
      ERR
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k < 4'd10;
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k >= KEY_ADD) && (k <= KEY_DIV);
   endfunction

   // Operator keys are contiguous, so the op code is the offset from KEY_ADD
   function automatic logic [1:0] key_to_op(input logic [3:0] k);
      return 2'(k - KEY_ADD);
   endfunction

endpackage

// File: rtl/calc_operand_accum.sv
// rtl/calc_operand_accum.sv - decimal digit accumulator with overflow detect
module calc_operand_accum #(
   parameter int IN_SIZE = 4
) (
   input  logic [IN_SIZE-1:0] value,
   input  logic [3:0]         digit,
   output logic [IN_SIZE-1:0] value_next,
   output logic               overflow
);

   // Four extra bits hold value*10+9 for any operand width
   localparam logic [IN_SIZE+3:0] TEN = (IN_SIZE+4)'(10);

   logic [IN_SIZE+3:0] wide;

   // Shift in one decimal digit and flag anything past the operand range
   always_comb begin
      wide       = {4'b0000, value} * TEN + {{IN_SIZE{1'b0}}, digit};
      value_next = wide[IN_SIZE-1:0];
      overflow   = |wide[IN_SIZE+3:IN_SIZE];
   end

endmodule

// File: rtl/calc_alu_sequencer.sv
// rtl/calc_alu_sequencer.sv - keypad-driven operand entry and ALU request sequencer
module calc_alu_sequencer
   import calc_pkg::*;
#(
   parameter int IN_SIZE = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_valid,
   input  logic [3:0]             key_code,
   output logic                   alu_en,
   output logic [1:0]             alu_op,
   output logic [IN_SIZE-1:0]     alu_a,
   output logic [IN_SIZE-1:0]     alu_b,
   input  logic [2*IN_SIZE-1:0]   alu_result,
   input  logic                   alu_valid,
   output logic [2*IN_SIZE-1:0]   disp_value,
   output logic                   disp_valid,
   output logic                   busy,
   output logic                   error
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t                 state_q, state_d;
   logic [IN_SIZE-1:0]     a_q, a_d;
   logic [IN_SIZE-1:0]     b_q, b_d;
   logic [1:0]             op_q, op_d;
   logic [2*IN_SIZE-1:0]   res_q, res_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [IN_SIZE-1:0]     a_acc, b_acc;
   logic                   a_ovf, b_ovf;
   logic [IN_SIZE-1:0]     digit_ext;

   assign digit_ext = IN_SIZE'(key_code);

   calc_operand_accum #(.IN_SIZE(IN_SIZE)) u_accum_a (
      .value      (a_q),
      .digit      (key_code),
      .value_next (a_acc),
      .overflow   (a_ovf)
   );

   calc_operand_accum #(.IN_SIZE(IN_SIZE)) u_accum_b (
      .value      (b_q),
      .digit      (key_code),
      .value_next (b_acc),
      .overflow   (b_ovf)
   );

   // State and datapath registers; operands only move on accepted keys
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ENTER_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   // Key handling, ALU handshake and timeout; clear overrides everything
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;

      if (key_valid && key_code == KEY_CLR) begin
         state_d = ENTER_A;
         a_d     = '0;
         b_d     = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ENTER_A: begin
               if (key_valid) begin
                  if (is_digit(key_code)) begin
                     if (a_ovf) state_d = ERR;
                     else       a_d     = a_acc;
                  end else if (is_op(key_code)) begin
                     op_d    = key_to_op(key_code);
                     b_d     = '0;
                     state_d = ENTER_B;
                  end
               end
            end
            ENTER_B: begin
               if (key_valid) begin
                  if (is_digit(key_code)) begin
                     if (b_ovf) state_d = ERR;
                     else       b_d     = b_acc;
                  end else if (is_op(key_code)) begin
                     op_d = key_to_op(key_code);
                  end else if (key_code == KEY_EQ) begin
                     if (op_q == OP_DIV && b_q == '0) state_d = ERR;
                     else                             state_d = ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt_d = '0;
               if (alu_valid) begin
                  res_d   = alu_result;
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (alu_valid) begin
                  res_d   = alu_result;
                  cnt_d   = '0;
                  state_d = DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  cnt_d   = '0;
                  state_d = ERR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (key_valid) begin
                  if (is_digit(key_code)) begin
                     a_d     = digit_ext;
                     state_d = ENTER_A;
                  end else if (is_op(key_code)) begin
                     if (res_q[2*IN_SIZE-1:IN_SIZE] == '0) begin
                        a_d     = res_q[IN_SIZE-1:0];
                        op_d    = key_to_op(key_code);
                        b_d     = '0;
                        state_d = ENTER_B;
                     end else begin
                        state_d = ERR;
                     end
                  end
               end
            end
            ERR: begin
               state_d = ERR;
            end
            default: begin
               state_d = ENTER_A;
            end
         endcase
      end
   end

   // Status flags and display selection follow the registered state
   always_comb begin
      alu_en     = (state_q == ISSUE);
      busy       = (state_q == ISSUE) || (state_q == WAIT);
      disp_valid = (state_q == DONE);
      error      = (state_q == ERR);
      alu_op     = op_q;
      alu_a      = a_q;
      alu_b      = b_q;
      case (state_q)
         ENTER_A: disp_value = {{IN_SIZE{1'b0}}, a_q};
         ENTER_B: disp_value = {{IN_SIZE{1'b0}}, b_q};
         ERR:     disp_value = '0;
         default: disp_value = res_q;
      endcase
   end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb/tb_calc_alu_sequencer.sv - self-checking bench for calc_alu_sequencer
module tb_calc_alu_sequencer;

   localparam int N    = 4;
   localparam int TO   = 16;
   localparam int MAXV = (1 << N) - 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           key_valid = 1'b0;
   logic [3:0]     key_code = 4'd0;
   logic           alu_en;
   logic [1:0]     alu_op;
   logic [N-1:0]   alu_a;
   logic [N-1:0]   alu_b;
   logic [2*N-1:0] alu_result = '0;
   logic           alu_valid = 1'b0;
   logic [2*N-1:0] disp_value;
   logic           disp_valid;
   logic           busy;
   logic           error;

   int checks = 0;
   int errors = 0;
   int en_cnt = 0;
   int busy_cnt = 0;

   always #5 clk = ~clk;

   calc_alu_sequencer #(.IN_SIZE(N), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .alu_en     (alu_en),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_valid  (alu_valid),
      .disp_value (disp_value),
      .disp_valid (disp_valid),
      .busy       (busy),
      .error      (error)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: calculator phases with plain integer arithmetic
   localparam int PA = 0, PB = 1, PI = 2, PW = 3, PD = 4, PE = 5;
   int ph = PA, ma = 0, mb = 0, mop = 0, mres = 0, mwait = 0;

   always @(posedge clk or posedge rst) begin
      int k, v;
      if (rst) begin
         ph = PA; ma = 0; mb = 0; mop = 0; mres = 0; mwait = 0;
      end else begin
         k = int'(key_code);
         if (key_valid && k == 15) begin
            ph = PA; ma = 0; mb = 0; mwait = 0;
         end else if (ph == PA) begin
            if (key_valid && k < 10) begin
               v = ma * 10 + k;
               if (v > MAXV) ph = PE; else ma = v;
            end else if (key_valid && k <= 13) begin
               mop = k - 10; mb = 0; ph = PB;
            end
         end else if (ph == PB) begin
            if (key_valid && k < 10) begin
               v = mb * 10 + k;
               if (v > MAXV) ph = PE; else mb = v;
            end else if (key_valid && k <= 13) begin
               mop = k - 10;
            end else if (key_valid && k == 14) begin
               if (mop == 3 && mb == 0) ph = PE; else ph = PI;
            end
         end else if (ph == PI) begin
            if (alu_valid) begin mres = int'(alu_result); ph = PD; end
            else begin mwait = 0; ph = PW; end
         end else if (ph == PW) begin
            mwait++;
            if (alu_valid) begin mres = int'(alu_result); ph = PD; end
            else if (mwait == TO) ph = PE;
         end else if (ph == PD) begin
            if (key_valid && k < 10) begin
               ma = k; ph = PA;
            end else if (key_valid && k <= 13) begin
               if (mres > MAXV) ph = PE;
               else begin ma = mres; mop = k - 10; mb = 0; ph = PB; end
            end
         end
      end
   end

   // Every cycle out of reset, the DUT must match the model
   always @(negedge clk) begin
      int exp_disp;
      if (!rst) begin
         exp_disp = (ph == PA) ? ma : (ph == PB) ? mb : (ph == PE) ? 0 : mres;
         chk("cyc_alu_en", 32'(alu_en), 32'(ph == PI));
         chk("cyc_busy", 32'(busy), 32'(ph == PI || ph == PW));
         chk("cyc_error", 32'(error), 32'(ph == PE));
         chk("cyc_disp_valid", 32'(disp_valid), 32'(ph == PD));
         chk("cyc_disp_value", 32'(disp_value), 32'(exp_disp));
         chk("cyc_alu_a", 32'(alu_a), 32'(ma));
         chk("cyc_alu_b", 32'(alu_b), 32'(mb));
         chk("cyc_alu_op", 32'(alu_op), 32'(mop));
         if (alu_en) en_cnt++;
         if (busy) busy_cnt++;
      end
   end

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int k);
      key_valid = 1'b1;
      key_code  = 4'(k);
      cycle(1);
      key_valid = 1'b0;
   endtask

   task automatic respond(input int r);
      alu_valid  = 1'b1;
      alu_result = 8'(r);
      cycle(1);
      alu_valid  = 1'b0;
   endtask

   initial begin
      int r, p, vmode;
      vmode = 0;
      cycle(2);
      rst = 1'b0;
      chk("rst_alu_en", 32'(alu_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_disp_valid", 32'(disp_valid), 0);
      chk("rst_disp_value", 32'(disp_value), 0);
      chk("rst_alu_a", 32'(alu_a), 0);

      // 7 + 5, ALU answers three cycles after the request
      cycle(1);
      en_cnt = 0; busy_cnt = 0;
      press(7); press(10); press(5); press(14);
      chk("t1_en", 32'(alu_en), 1);
      chk("t1_a", 32'(alu_a), 7);
      chk("t1_b", 32'(alu_b), 5);
      chk("t1_op", 32'(alu_op), 0);
      cycle(3);
      respond(12);
      chk("t1_disp", 32'(disp_value), 12);
      chk("t1_dvalid", 32'(disp_valid), 1);
      chk("t1_busy_after", 32'(busy), 0);
      chk("t1_en_cycles", 32'(en_cnt), 1);
      chk("t1_busy_cycles", 32'(busy_cnt), 4);
      chk("t1_model_res", 32'(mres), 12);

      // chain 12 * 2 with a zero-latency ALU
      press(12); press(2); press(14);
      chk("chain_a", 32'(alu_a), 12);
      chk("chain_b", 32'(alu_b), 2);
      chk("chain_op", 32'(alu_op), 2);
      respond(24);
      chk("chain_disp", 32'(disp_value), 24);
      chk("chain_dvalid", 32'(disp_valid), 1);

      // operand overflow 16 > 15
      press(15);
      en_cnt = 0;
      press(1); press(6);
      chk("ovf_error", 32'(error), 1);
      chk("ovf_model", 32'(ph), PE);
      press(15);
      chk("clr_error", 32'(error), 0);
      chk("clr_disp", 32'(disp_value), 0);
      chk("clr_dvalid", 32'(disp_valid), 0);

      // divide by zero, then ignored keys in ERR
      press(9); press(13); press(0); press(14);
      chk("div0_error", 32'(error), 1);
      press(7); press(14);
      chk("div0_stuck", 32'(error), 1);
      chk("div0_disp", 32'(disp_value), 0);
      chk("no_en_cycles", 32'(en_cnt), 0);
      press(15);

      // 4*5=20 cannot chain into a 4-bit operand
      press(4); press(12); press(5); press(14);
      respond(20);
      chk("r20_disp", 32'(disp_value), 20);
      press(10);
      chk("r20_chain_err", 32'(error), 1);
      press(15);

      // operator replacement 8 - 3
      press(8); press(10); press(11); press(3); press(14);
      chk("repl_op", 32'(alu_op), 1);
      chk("repl_a", 32'(alu_a), 8);
      cycle(1);
      respond(5);
      chk("repl_disp", 32'(disp_value), 5);
      press(15);

      // timeout, then a late response
      press(3); press(12); press(4); press(14);
      cycle(1);
      cycle(TO - 1);
      chk("to_still_busy", 32'(busy), 1);
      chk("to_not_err", 32'(error), 0);
      cycle(1);
      chk("to_error", 32'(error), 1);
      chk("to_busy_off", 32'(busy), 0);
      cycle(4);
      respond(99);
      chk("late_dvalid", 32'(disp_valid), 0);
      chk("late_error", 32'(error), 1);
      chk("late_disp", 32'(disp_value), 0);
      press(15);

      // asynchronous reset while waiting
      press(2); press(11); press(3); press(14);
      cycle(2);
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_en", 32'(alu_en), 0);
      chk("arst_op", 32'(alu_op), 0);
      chk("arst_a", 32'(alu_a), 0);
      chk("arst_b", 32'(alu_b), 0);
      chk("arst_disp", 32'(disp_value), 0);
      #1;
      rst = 1'b0;
      alu_valid  = 1'b1;
      alu_result = 8'd77;
      cycle(1);
      alu_valid = 1'b0;
      chk("arst_dvalid", 32'(disp_valid), 0);
      chk("arst_disp_after", 32'(disp_value), 0);
      chk("arst_busy_after", 32'(busy), 0);

      // randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         if (c % 250 == 0) vmode = int'($urandom_range(0, 2));
         key_valid = ($urandom_range(0, 2) == 0);
         r = int'($urandom_range(0, 19));
         if (r < 11)      key_code = 4'($urandom_range(0, 9));
         else if (r < 15) key_code = 4'($urandom_range(10, 13));
         else if (r < 18) key_code = 4'd14;
         else             key_code = 4'd15;
         p = (vmode == 0) ? 0 : (vmode == 1) ? 10 : 40;
         alu_valid = (int'($urandom_range(0, 99)) < p);
         if ($urandom_range(0, 3) != 0) alu_result = 8'($urandom_range(0, 15));
         else                           alu_result = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
         cycle(1);
      end
      key_valid = 1'b0;
      alu_valid = 1'b0;
      cycle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
